// File: rtl/mem_subword_rmw.sv
// -----------------------------------------------------------------------------
// mem_subword_rmw
//
// Sub-word access adapter between the load/store unit and one port of a
// word-only BRAM. Byte and halfword loads are served by reading the full word
// and extracting the lane, with sign or zero extension. Byte and halfword
// stores become a read-modify-write: read the word, merge the new lane(s),
// then write the full word back. Only one transaction is in flight at a time.
//
// Parameters
//   XLEN             data/address width (the lane logic assumes 32)
//   ERR_ON_MISALIGN  1: a misaligned access completes with lsu_err and no
//                       memory access
//                    0: low address bits are cleared to the access size and
//                       the access proceeds
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   lsu_req        request, sampled only while idle
//   lsu_we         1 = store, 0 = load
//   lsu_addr       byte address
//   lsu_wdata      right-aligned store data
//   lsu_size       00 byte, 01 half, 10 word, 11 illegal
//   lsu_unsigned   zero-extend loads when 1
//   lsu_rdata      load result; holds until the next load or error completes
//   lsu_ready      one-cycle completion pulse
//   lsu_err        error flag, valid with lsu_ready
//   lsu_busy       high whenever a transaction is in progress
//   mem_req        single-cycle BRAM request
//   mem_we         BRAM write enable
//   mem_addr       word-aligned BRAM address
//   mem_wdata      full word written to BRAM
//   mem_rdata      BRAM read data
//   mem_ready      BRAM completion, one cycle after mem_req
//
// Every output is a register or a decode of registered state, so there is no
// combinational path from the lsu_* inputs to the mem_* outputs.
//
// The read-modify-write is not atomic against the other BRAM port; words that
// are sub-word written here must not be shared with that port concurrently.
// -----------------------------------------------------------------------------
module mem_subword_rmw #(
  parameter int XLEN            = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_ready,
  output logic            lsu_err,
  output logic            lsu_busy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state_q, state_d;

  // Captured transaction. wdata_q holds the raw store data first and is
  // overwritten with the merged word once the read returns.
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  // Request decode (only meaningful in IDLE).
  logic            req_misaligned;
  logic            req_illegal;
  logic            req_err;
  logic [XLEN-1:0] req_addr;

  // Read-data processing (only meaningful in RD_WAIT).
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    req_misaligned = 1'b0;
    req_illegal    = 1'b0;
    req_addr       = lsu_addr;
    case (lsu_size)
      SZ_BYTE: ;
      SZ_HALF: begin
        req_misaligned = lsu_addr[0];
        req_addr       = {lsu_addr[XLEN-1:1], 1'b0};
      end
      SZ_WORD: begin
        req_misaligned = |lsu_addr[1:0];
        req_addr       = {lsu_addr[XLEN-1:2], 2'b00};
      end
      default: req_illegal = 1'b1;
    endcase
    req_err = req_illegal || (ERR_ON_MISALIGN && req_misaligned);
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and store merge, both against the returning word
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_lane = mem_rdata[8*addr_q[1:0] +: 8];
    half_lane = mem_rdata[16*addr_q[1] +: 16];

    case (size_q)
      SZ_BYTE: load_val = unsigned_q ? {{(XLEN-8){1'b0}}, byte_lane}
                                     : {{(XLEN-8){byte_lane[7]}}, byte_lane};
      SZ_HALF: load_val = unsigned_q ? {{(XLEN-16){1'b0}}, half_lane}
                                     : {{(XLEN-16){half_lane[15]}}, half_lane};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    case (size_q)
      SZ_BYTE: merged[8*addr_q[1:0] +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[16*addr_q[1] +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          if (req_err)                          state_d = S_DONE;
          else if (lsu_we && lsu_size == SZ_WORD) state_d = S_WR;
          else                                  state_d = S_RD;
        end
      end
      S_RD:      state_d = S_RD_WAIT;
      S_RD_WAIT: if (mem_ready) state_d = we_q ? S_WR : S_DONE;
      S_WR:      state_d = S_WR_WAIT;
      S_WR_WAIT: if (mem_ready) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (lsu_req) begin
            we_q       <= lsu_we;
            addr_q     <= req_addr;
            wdata_q    <= lsu_wdata;
            size_q     <= lsu_size;
            unsigned_q <= lsu_unsigned;
            err_q      <= req_err;
            // An error completes as a load would, with zero data.
            if (req_err) rdata_q <= '0;
          end
        end
        S_RD_WAIT: begin
          if (mem_ready) begin
            if (we_q) wdata_q <= merged;
            else      rdata_q <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // ---------------------------------------------------------------------------
  assign mem_req   = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign lsu_rdata = rdata_q;
  assign lsu_ready = (state_q == S_DONE);
  assign lsu_err   = (state_q == S_DONE) && err_q;
  assign lsu_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_subword_rmw.sv
// -----------------------------------------------------------------------------
// tb_mem_subword_rmw
//
// Directed bench for mem_subword_rmw. u_dut (ERR_ON_MISALIGN = 1) is attached
// to a small word-addressed BRAM model that answers one cycle after mem_req.
// u_dut_nm (ERR_ON_MISALIGN = 0) shares the lsu inputs but has its own request
// line and a responder that returns 0xA5000000 | address, used only for the
// forced-alignment case.
// -----------------------------------------------------------------------------
module tb_mem_subword_rmw;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lsu_req = 1'b0;
  logic            lsu_req_nm = 1'b0;
  logic            lsu_we = 1'b0;
  logic [XLEN-1:0] lsu_addr = '0;
  logic [XLEN-1:0] lsu_wdata = '0;
  logic [1:0]      lsu_size = 2'b00;
  logic            lsu_unsigned = 1'b0;

  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_ready, lsu_err, lsu_busy;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_ready = 1'b0;

  logic [XLEN-1:0] nm_rdata;
  logic            nm_ready, nm_err, nm_busy;
  logic            nm_req, nm_we;
  logic [XLEN-1:0] nm_addr, nm_wdata;
  logic [XLEN-1:0] nm_mem_rdata = '0;
  logic            nm_mem_ready = 1'b0;
  logic [XLEN-1:0] nm_addr_seen = '0;

  always #5 clk = ~clk;

  mem_subword_rmw #(.XLEN(XLEN), .ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .lsu_rdata(lsu_rdata), .lsu_ready(lsu_ready), .lsu_err(lsu_err),
    .lsu_busy(lsu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  mem_subword_rmw #(.XLEN(XLEN), .ERR_ON_MISALIGN(1'b0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n),
    .lsu_req(lsu_req_nm), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_size(lsu_size), .lsu_unsigned(lsu_unsigned),
    .lsu_rdata(nm_rdata), .lsu_ready(nm_ready), .lsu_err(nm_err),
    .lsu_busy(nm_busy),
    .mem_req(nm_req), .mem_we(nm_we), .mem_addr(nm_addr),
    .mem_wdata(nm_wdata), .mem_rdata(nm_mem_rdata), .mem_ready(nm_mem_ready)
  );

  // BRAM model: 64 words, answers every request one cycle later.
  logic [31:0] mem [0:63];
  int          n_writes = 0;

  always @(posedge clk) begin
    mem_ready <= mem_req;
    if (mem_req) begin
      if (mem_we) begin
        mem[mem_addr[7:2]] <= mem_wdata;
        n_writes <= n_writes + 1;
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  always @(posedge clk) begin
    nm_mem_ready <= nm_req;
    if (nm_req) begin
      nm_mem_rdata <= 32'hA500_0000 | nm_addr;
      nm_addr_seen <= nm_addr;
    end
  end

  // mem_req must never be high on two consecutive cycles.
  logic prev_req = 1'b0;
  int   n_double_req = 0;
  always @(negedge clk) begin
    if (mem_req && prev_req) n_double_req <= n_double_req + 1;
    prev_req <= mem_req;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the last transaction.
  int          t_cyc, t_reads, t_writes;
  logic [31:0] t_rdata, t_raddr, t_waddr, t_wdata;
  logic        t_err;

  // Issue one transaction on u_dut and follow it cycle by cycle. Cycle 0 is
  // the accepting edge; outputs are sampled on the falling edge.
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size,
                         input logic uns);
    @(negedge clk);
    lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
    lsu_size = size; lsu_unsigned = uns; lsu_req = 1'b1;
    @(posedge clk);
    #1 lsu_req = 1'b0;
    t_cyc = -1; t_reads = 0; t_writes = 0;
    t_rdata = '0; t_raddr = '0; t_waddr = '0; t_wdata = '0; t_err = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) begin t_reads++;  t_raddr = mem_addr; end
      if (mem_req &&  mem_we) begin t_writes++; t_waddr = mem_addr; t_wdata = mem_wdata; end
      if (lsu_ready) begin
        t_cyc = c; t_rdata = lsu_rdata; t_err = lsu_err;
        break;
      end
    end
    if (t_cyc < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'h8899AABB;
    mem[32'h20 >> 2] = 32'h11223344;
    mem[32'h50 >> 2] = 32'hCAFEF00D;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {lsu_rdata[27:0], lsu_ready, lsu_err, lsu_busy, mem_req}, 32'h0);
    check("rst_mem", {mem_we, mem_addr[30:0]} | mem_wdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Byte load signed / unsigned from 0x12 of 0x8899AABB
    run_txn(1'b0, 32'h12, 32'h0, 2'b00, 1'b0);
    check("lb_s_data",  t_rdata, 32'hFFFFFF99);
    check("lb_s_cyc",   t_cyc,   32'd3);
    check("lb_s_err",   t_err,   32'd0);
    check("lb_s_raddr", t_raddr, 32'h10);
    run_txn(1'b0, 32'h12, 32'h0, 2'b00, 1'b1);
    check("lb_u_data",  t_rdata, 32'h00000099);
    check("lb_u_cyc",   t_cyc,   32'd3);

    // Half store RMW of 0xBEEF to 0x22 over 0x11223344
    run_txn(1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0);
    check("sh_cyc",    t_cyc,    32'd5);
    check("sh_reads",  t_reads,  32'd1);
    check("sh_writes", t_writes, 32'd1);
    check("sh_wdata",  t_wdata,  32'hBEEF3344);
    check("sh_waddr",  t_waddr,  32'h20);
    check("sh_rdata_held", t_rdata, 32'h00000099);
    run_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    check("lw_after_sh", t_rdata, 32'hBEEF3344);
    run_txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
    check("lh_s_data", t_rdata, 32'hFFFFBEEF);
    run_txn(1'b0, 32'h11, 32'h0, 2'b00, 1'b1);
    check("lb_u_lane1", t_rdata, 32'h000000AA);

    // Byte store RMW to lane 3
    run_txn(1'b1, 32'h13, 32'h00000055, 2'b00, 1'b0);
    check("sb_wdata", t_wdata, 32'h5599AABB);
    check("sb_cyc",   t_cyc,   32'd5);

    // Word store: write only, no read
    run_txn(1'b1, 32'h30, 32'hDEADBEEF, 2'b10, 1'b0);
    check("sw_cyc",    t_cyc,    32'd3);
    check("sw_reads",  t_reads,  32'd0);
    check("sw_writes", t_writes, 32'd1);
    check("sw_wdata",  t_wdata,  32'hDEADBEEF);
    run_txn(1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    check("lw_after_sw", t_rdata, 32'hDEADBEEF);

    // Misaligned word load with error enabled
    run_txn(1'b0, 32'h41, 32'h0, 2'b10, 1'b0);
    check("mis_cyc",   t_cyc,   32'd1);
    check("mis_err",   t_err,   32'd1);
    check("mis_rdata", t_rdata, 32'h0);
    check("mis_reqs",  t_reads + t_writes, 32'd0);

    // Misaligned half store with error enabled leaves memory alone
    run_txn(1'b1, 32'h21, 32'h00001234, 2'b01, 1'b0);
    check("mis_sh_err",  t_err, 32'd1);
    check("mis_sh_reqs", t_reads + t_writes, 32'd0);

    // Illegal size
    run_txn(1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    check("ill_cyc",  t_cyc, 32'd1);
    check("ill_err",  t_err, 32'd1);
    check("ill_reqs", t_reads + t_writes, 32'd0);

    // Forced alignment on u_dut_nm: word load at 0x43 reads word 0x40
    begin
      int nm_cyc;
      logic [31:0] nm_data;
      logic nm_e;
      nm_cyc = -1; nm_data = '0; nm_e = 1'b1;
      @(negedge clk);
      lsu_we = 1'b0; lsu_addr = 32'h43; lsu_size = 2'b10;
      lsu_unsigned = 1'b0; lsu_req_nm = 1'b1;
      @(posedge clk);
      #1 lsu_req_nm = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (nm_ready) begin nm_cyc = c; nm_data = nm_rdata; nm_e = nm_err; break; end
      end
      check("nm_cyc",  nm_cyc,       32'd3);
      check("nm_addr", nm_addr_seen, 32'h40);
      check("nm_data", nm_data,      32'hA5000040);
      check("nm_err",  nm_e,         32'd0);
    end

    // Back-to-back loads with lsu_req held high
    begin
      int cyc, acc0, acc1, n_acc, n_rdy, run, max_run;
      logic prev_busy;
      cyc = 0; acc0 = -1; acc1 = -1; n_acc = 0; n_rdy = 0;
      run = 0; max_run = 0; prev_busy = 1'b0;
      @(negedge clk);
      lsu_we = 1'b0; lsu_addr = 32'h10; lsu_size = 2'b10;
      lsu_unsigned = 1'b0; lsu_req = 1'b1;
      for (int c = 0; c < 30 && n_rdy < 2; c++) begin
        @(negedge clk);
        cyc++;
        if (lsu_busy && !prev_busy) begin
          if (n_acc == 0) acc0 = cyc; else if (n_acc == 1) acc1 = cyc;
          n_acc++;
        end
        prev_busy = lsu_busy;
        if (lsu_ready) begin
          run++;
          if (run > max_run) max_run = run;
          n_rdy++;
          if (n_rdy == 2) lsu_req = 1'b0;
        end else begin
          run = 0;
        end
      end
      lsu_req = 1'b0;
      check("b2b_interval",  acc1 - acc0, 32'd4);
      check("b2b_ready_cnt", n_rdy,       32'd2);
      check("b2b_ready_w",   max_run,     32'd1);
      check("b2b_rdata",     lsu_rdata,   32'h5599AABB);
      repeat (4) @(negedge clk);
      check("b2b_idle", lsu_busy, 32'd0);
    end

    // Reset during RD_WAIT of a byte store
    begin
      int w_before;
      w_before = n_writes;
      @(negedge clk);
      lsu_we = 1'b1; lsu_addr = 32'h51; lsu_wdata = 32'h77;
      lsu_size = 2'b00; lsu_req = 1'b1;
      @(posedge clk);
      #1 lsu_req = 1'b0;
      @(negedge clk);   // cycle 1: RD
      @(negedge clk);   // cycle 2: RD_WAIT
      rst_n = 1'b0;
      #1;
      check("mrst_ctrl",
            {27'd0, lsu_ready, lsu_err, lsu_busy, mem_req, mem_we}, 32'h0);
      check("mrst_addr",  mem_addr,  32'h0);
      check("mrst_wdata", mem_wdata, 32'h0);
      check("mrst_rdata", lsu_rdata, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("mrst_no_write", n_writes - w_before, 32'd0);
      check("mrst_mem",      mem[32'h50 >> 2],    32'hCAFEF00D);
      check("mrst_idle",     lsu_busy,            32'd0);
    end

    check("no_double_req", n_double_req, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_subword_rmw.md
# mem_subword_rmw

Sub-word access adapter between the load/store unit and one port of the word-only dual-port BRAM. The BRAM has no byte enables, so this block turns byte, halfword and word loads and stores into word-wide BRAM transactions. Loads get lane extraction and sign/zero extension. Sub-word stores become a read-modify-write sequence. It drives a single BRAM port through the standard mem request/response signal set and handles one transaction at a time.

## Interface
- `ERR_ON_MISALIGN`, default 1: 1 = misaligned access returns an error without touching memory; 0 = low address bits are force-cleared to the access size and the access proceeds.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `lsu_req` in 1: transaction request, sampled only in IDLE.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_addr` in `XLEN`: byte address.
- `lsu_wdata` in `XLEN`: store data, right-aligned (byte in [7:0], half in [15:0]).
- `lsu_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `lsu_unsigned` in 1: zero-extend loads when 1.
- `lsu_rdata` out `XLEN`: load result, valid while `lsu_ready`.
- `lsu_ready` out 1: one-cycle completion pulse.
- `lsu_err` out 1: valid with `lsu_ready`; misaligned or illegal size.
- `lsu_busy` out 1: high whenever state is not IDLE.
- `mem_req` out 1: BRAM request, single-cycle pulse.
- `mem_we` out 1: BRAM write enable.
- `mem_addr` out `XLEN`: word-aligned BRAM address ([1:0] = 0).
- `mem_wdata` out `XLEN`: full word written to BRAM.
- `mem_rdata` in `XLEN`: BRAM read data.
- `mem_ready` in 1: BRAM completion, one cycle after `mem_req`.

## Operation
- **States:** IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE.
- **IDLE:** on `lsu_req`, capture we/addr/wdata/size/unsigned into registers.
  - Error path (size 11, or misaligned with `ERR_ON_MISALIGN` = 1): go to DONE with err = 1 and rdata = 0. No memory access.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- **RD:** `mem_req` = 1, `mem_we` = 0, `mem_addr` = {addr[XLEN-1:2], 2'b00}. Next state is RD_WAIT.
- **RD_WAIT:** hold until `mem_ready`. On `mem_ready`:
  - Load: extract the lane; byte uses addr[1:0], half uses addr[1]. Sign-extend from bit 7 or 15 unless unsigned. Register into `lsu_rdata` and go to DONE.
  - Store: merge `lsu_wdata` into the read word. Byte replaces lane addr[1:0]; half replaces bytes {addr[1],0} and {addr[1],1}. Register the merged word and go to WR.
- **WR:** `mem_req` = 1, `mem_we` = 1, `mem_wdata` = merged word (or raw wdata for a word store). Next state is WR_WAIT.
- **WR_WAIT:** hold until `mem_ready`, then go to DONE.
- **DONE:** `lsu_ready` = 1 for exactly one cycle. `lsu_req` is ignored. Next state is IDLE.
- **`lsu_rdata`:** holds its last value until the next load or error completes. Stores do not change it.
- **Stray `mem_ready`:** ignored in IDLE, RD, WR and DONE.
- **Atomicity:** RMW is not atomic against the other BRAM port. System software must not share sub-word-written words across ports concurrently.

## Timing
- **Reset values:** asynchronous reset forces IDLE. All outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `lsu_rdata`, `lsu_ready`, `lsu_err`, `lsu_busy`.
- **Reset mid-transaction:** the transaction is abandoned. A pending RMW write is never issued.
- **Output timing:** all outputs are registered or decoded from registered state. There is no combinational path from `lsu_*` inputs to `mem_*` outputs.
- **Latency,** counting from the accepting edge as cycle 0, when `mem_ready` arrives one cycle after `mem_req`:
  - Load: `mem_req` in cycle 1, `lsu_ready` in cycle 3.
  - Word store: `mem_req` in cycle 1, `lsu_ready` in cycle 3.
  - Sub-word store: read `mem_req` in cycle 1, write `mem_req` in cycle 3, `lsu_ready` in cycle 5.
  - Error: `lsu_ready` in cycle 1.
- **Back-to-back:** if `lsu_req` is held high, the next request is accepted in the cycle after DONE. The minimum issue interval is therefore 4 cycles for loads and word stores.
- **Request pulse:** `mem_req` is never high for two consecutive cycles.

## Test plan
- **Byte load, signed and unsigned:** mem[0x10] = 0x8899AABB. Load byte at 0x12 signed gives rdata 0xFFFFFF99. Load byte at 0x12 unsigned gives 0x00000099. `lsu_ready` appears 3 cycles after accept in both cases.
- **Half store RMW:** mem[0x20] = 0x11223344. Store half 0xBEEF to 0x22. Expect one read then one write of 0xBEEF3344, and `lsu_ready` at cycle 5. A following word load of 0x20 returns 0xBEEF3344.
- **Word store:** store 0xDEADBEEF to 0x30. Expect exactly one `mem_req` (we = 1, no read), `mem_wdata` 0xDEADBEEF, and `lsu_ready` at cycle 3.
- **Misalignment:**
  - With `ERR_ON_MISALIGN` = 1, a word load at 0x41 gives `lsu_ready` and `lsu_err` at cycle 1, rdata 0, and no `mem_req`.
  - With size 11 at any address, the same error response occurs.
  - With `ERR_ON_MISALIGN` = 0, a word load at 0x43 reads word 0x40.
- **Back-to-back with held request:** hold `lsu_req` high for two loads. The accepts are exactly 4 cycles apart, `lsu_ready` is one cycle wide each time, and `mem_req` is never high for two consecutive cycles.
- **Reset mid-RMW:** assert `rst_n` low during RD_WAIT of a byte store. All outputs go to 0 immediately, no write is issued, and the memory word is unchanged after reset release.
